simon_sequencer: RTL and testbench



---
 rtl/simon_pkg.sv | 35 +++
 rtl/simon_sequencer_if.sv | 28 ++
 rtl/simon_sequencer_seq_mem.sv | 25 ++
 rtl/simon_sequencer.sv | 183 ++++++++++++++++++
 tb/tb_simon_sequencer.sv | 250 +++++++++++++++++++++++++
 5 files changed

// File: rtl/simon_pkg.sv
// Shared types and constants for the Simon sequencer.
package simon_pkg;

  typedef enum logic [2:0] {
    IDLE,
    EXTEND,
    SHOW_ON,
    SHOW_OFF,
    WAIT_IN,
    PAUSE,
    WIN,
    LOSE
  } state_t;

  typedef logic [1:0] color_t;

  localparam color_t RED    = 2'd0;
  localparam color_t GREEN  = 2'd1;
  localparam color_t BLUE   = 2'd2;
  localparam color_t YELLOW = 2'd3;

  // Larger of three counts.
  function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

  // Bits needed to count 0..n-1, never less than one.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/simon_sequencer_if.sv
// Game-side signal bundle between the sequencer and its LFSR, buttons and LED/score devices.
interface simon_sequencer_if #(
  parameter int unsigned LEN_W = 6
);
  import simon_pkg::*;

  logic             start;
  logic [31:0]      rand_in;
  logic             btn_valid;
  color_t           btn_color;
  logic             led_on;
  color_t           led_color;
  logic             awaiting_input;
  logic [LEN_W-1:0] level;
  logic             win;
  logic             fail;

  modport master (
    output start, rand_in, btn_valid, btn_color,
    input  led_on, led_color, awaiting_input, level, win, fail
  );

  modport slave (
    input  start, rand_in, btn_valid, btn_color,
    output led_on, led_color, awaiting_input, level, win, fail
  );

endinterface

// File: rtl/simon_sequencer_seq_mem.sv
// Colour sequence storage: synchronous write, asynchronous read, no reset.
module seq_mem
  import simon_pkg::*;
#(
  parameter int unsigned DEPTH = 32,
  parameter int unsigned AW    = 5
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  color_t        wdata,
  input  logic [AW-1:0] raddr,
  output color_t        rdata
);

  color_t mem [DEPTH];

  // Store the newly appended colour.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/simon_sequencer.sv
// Simon game controller: extends, replays and checks the colour sequence.
// Optional SEQ_TIMEOUT_EN: lose the game after TIMEOUT_CYCLES without a press.
module simon_sequencer
  import simon_pkg::*;
#(
  parameter int unsigned MAX_LEN        = 32,
  parameter int unsigned ON_CYCLES      = 25000000,
  parameter int unsigned OFF_CYCLES     = 12500000,
  parameter int unsigned TIMEOUT_CYCLES = 250000000
) (
  input logic               clk,
  input logic               reset_n,
  simon_sequencer_if.slave  bus
);

  localparam int unsigned LEN_W = $clog2(MAX_LEN + 1);
  localparam int unsigned IDX_W = cnt_width(MAX_LEN);
  localparam int unsigned TMR_W = cnt_width(max3(ON_CYCLES, OFF_CYCLES, TIMEOUT_CYCLES));

  state_t           state, state_next;
  logic [LEN_W-1:0] level, level_next;
  logic [IDX_W-1:0] idx, idx_next;
  logic [TMR_W-1:0] timer, timer_next;
  logic             mem_we;
  color_t           rd_color;
  logic             last;
  logic             match;
  logic             on_done, off_done;

  logic led_on_r, await_r, win_r, fail_r;
  logic led_on_d, await_d, win_d, fail_d;

  logic unused_rand;
  assign unused_rand = ^bus.rand_in[31:2];

  seq_mem #(
    .DEPTH (MAX_LEN),
    .AW    (IDX_W)
  ) u_mem (
    .clk   (clk),
    .we    (mem_we),
    .waddr (IDX_W'(level)),
    .wdata (bus.rand_in[1:0]),
    .raddr (idx),
    .rdata (rd_color)
  );

  assign last     = (LEN_W'(idx) + LEN_W'(1)) == level;
  assign match    = bus.btn_color == rd_color;
  assign on_done  = timer == TMR_W'(ON_CYCLES - 1);
  assign off_done = timer == TMR_W'(OFF_CYCLES - 1);

  // State and datapath registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      level <= '0;
      idx   <= '0;
      timer <= '0;
    end else begin
      state <= state_next;
      level <= level_next;
      idx   <= idx_next;
      timer <= timer_next;
    end
  end

  // Next-state, counter and memory-write decisions.
  always_comb begin
    state_next = state;
    level_next = level;
    idx_next   = idx;
    timer_next = timer;
    mem_we     = 1'b0;
    case (state)
      IDLE, WIN, LOSE: begin
        if (bus.start) begin
          level_next = '0;
          state_next = EXTEND;
        end
      end
      EXTEND: begin
        mem_we     = 1'b1;
        level_next = level + LEN_W'(1);
        idx_next   = '0;
        timer_next = '0;
        state_next = SHOW_ON;
      end
      SHOW_ON: begin
        if (on_done) begin
          timer_next = '0;
          state_next = SHOW_OFF;
        end else begin
          timer_next = timer + TMR_W'(1);
        end
      end
      SHOW_OFF: begin
        if (off_done) begin
          timer_next = '0;
          if (last) begin
            idx_next   = '0;
            state_next = WAIT_IN;
          end else begin
            idx_next   = idx + IDX_W'(1);
            state_next = SHOW_ON;
          end
        end else begin
          timer_next = timer + TMR_W'(1);
        end
      end
      WAIT_IN: begin
        if (bus.btn_valid) begin
          if (match) begin
            timer_next = '0;
            if (!last) begin
              idx_next = idx + IDX_W'(1);
            end else if (level == LEN_W'(MAX_LEN)) begin
              state_next = WIN;
            end else begin
              state_next = PAUSE;
            end
          end else begin
            state_next = LOSE;
          end
        end
`ifdef SEQ_TIMEOUT_EN
        else if (timer == TMR_W'(TIMEOUT_CYCLES - 1)) begin
          state_next = LOSE;
        end else begin
          timer_next = timer + TMR_W'(1);
        end
`endif
      end
      PAUSE: begin
        if (off_done) begin
          timer_next = '0;
          state_next = EXTEND;
        end else begin
          timer_next = timer + TMR_W'(1);
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Output decodes of the upcoming state.
  always_comb begin
    led_on_d = 1'b0;
    await_d  = 1'b0;
    win_d    = 1'b0;
    fail_d   = 1'b0;
    case (state_next)
      SHOW_ON: led_on_d = 1'b1;
      WAIT_IN: await_d  = 1'b1;
      WIN:     win_d    = 1'b1;
      LOSE:    fail_d   = 1'b1;
      default: ;
    endcase
  end

  // Registered outputs, cleared immediately by reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      led_on_r <= 1'b0;
      await_r  <= 1'b0;
      win_r    <= 1'b0;
      fail_r   <= 1'b0;
    end else begin
      led_on_r <= led_on_d;
      await_r  <= await_d;
      win_r    <= win_d;
      fail_r   <= fail_d;
    end
  end

  assign bus.led_on         = led_on_r;
  assign bus.led_color      = led_on_r ? rd_color : RED;
  assign bus.awaiting_input = await_r;
  assign bus.level          = level;
  assign bus.win            = win_r;
  assign bus.fail           = fail_r;

endmodule

// File: tb/tb_simon_sequencer.sv
// Directed bench for simon_sequencer with a game-rule timeline model.
module tb_simon_sequencer;
  import simon_pkg::*;

  localparam int unsigned MAX_LEN = 3;
  localparam int unsigned ON_C    = 4;
  localparam int unsigned OFF_C   = 2;
  localparam int unsigned TO_C    = 20;
  localparam int unsigned LEN_W   = $clog2(MAX_LEN + 1);

  logic clk = 1'b0;
  logic reset_n;

  always #5 clk = ~clk;

  simon_sequencer_if #(.LEN_W(LEN_W)) bus ();

  simon_sequencer #(
    .MAX_LEN        (MAX_LEN),
    .ON_CYCLES      (ON_C),
    .OFF_CYCLES     (OFF_C),
    .TIMEOUT_CYCLES (TO_C)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  int total = 0;
  int bad   = 0;

  // Expected outputs for the current cycle, and model values for the next one.
  bit     chk_en = 1'b0;
  bit     e_led, e_aw, e_win, e_fail;
  color_t e_col;
  int     e_lvl;
  bit     m_win, m_fail;
  int     m_lvl;
  color_t q[$];
  int     pos;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      check("led_on", 32'(bus.led_on), 32'(e_led));
      check("awaiting_input", 32'(bus.awaiting_input), 32'(e_aw));
      check("level", 32'(bus.level), 32'(e_lvl));
      check("win", 32'(bus.win), 32'(e_win));
      check("fail", 32'(bus.fail), 32'(e_fail));
      if (e_led) check("led_color", 32'(bus.led_color), 32'(e_col));
      if (bus.led_on && bus.awaiting_input) check("led_await_excl", 32'd1, 32'd0);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Advance one clock and publish what the outputs must show after it.
  task automatic cyc(input bit led, input color_t col, input bit aw);
    tick();
    e_led  = led;
    e_col  = col;
    e_aw   = aw;
    e_lvl  = m_lvl;
    e_win  = m_win;
    e_fail = m_fail;
  endtask

  // Replay of the whole sequence, ending in the first input-waiting cycle.
  task automatic show_all(input bit noisy);
    for (int i = 0; i < q.size(); i++) begin
      for (int k = 0; k < int'(ON_C); k++) begin
        cyc(1'b1, q[i], 1'b0);
        if (noisy && k == 0) begin
          bus.btn_valid = 1'b1;
          bus.btn_color = q[i] ^ 2'd1;
        end else begin
          bus.btn_valid = 1'b0;
        end
      end
      bus.btn_valid = 1'b0;
      repeat (OFF_C) cyc(1'b0, RED, 1'b0);
    end
    cyc(1'b0, RED, 1'b1);
    pos = 0;
  endtask

  task automatic start_game(input logic [31:0] r, input bit noisy);
    q.delete();
    m_lvl  = 0;
    m_win  = 1'b0;
    m_fail = 1'b0;
    bus.start   = 1'b1;
    bus.rand_in = r;
    cyc(1'b0, RED, 1'b0);
    bus.start = 1'b0;
    q.push_back(color_t'(r[1:0]));
    m_lvl = q.size();
    show_all(noisy);
  endtask

  // One button press; a round-completing press leaves the model in the first pause cycle.
  task automatic press(input color_t c);
    bus.btn_valid = 1'b1;
    bus.btn_color = c;
    if (c == q[pos]) begin
      if (pos + 1 < q.size()) begin
        pos++;
        cyc(1'b0, RED, 1'b1);
      end else if (q.size() == MAX_LEN) begin
        m_win = 1'b1;
        cyc(1'b0, RED, 1'b0);
      end else begin
        cyc(1'b0, RED, 1'b0);
      end
    end else begin
      m_fail = 1'b1;
      cyc(1'b0, RED, 1'b0);
    end
    bus.btn_valid = 1'b0;
  endtask

  // Rest of the pause, the extend cycle, then the replay.
  task automatic next_round(input logic [31:0] r, input bit noisy);
    repeat (OFF_C - 1) cyc(1'b0, RED, 1'b0);
    bus.rand_in = r;
    cyc(1'b0, RED, 1'b0);
    q.push_back(color_t'(r[1:0]));
    m_lvl = q.size();
    show_all(noisy);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n       = 1'b0;
    bus.start     = 1'b0;
    bus.rand_in   = 32'd0;
    bus.btn_valid = 1'b0;
    bus.btn_color = RED;
    m_lvl = 0; m_win = 1'b0; m_fail = 1'b0;
    e_led = 1'b0; e_aw = 1'b0; e_win = 1'b0; e_fail = 1'b0; e_col = RED; e_lvl = 0;
    #12;
    check("rst_led_on", 32'(bus.led_on), 32'd0);
    check("rst_await", 32'(bus.awaiting_input), 32'd0);
    check("rst_level", 32'(bus.level), 32'd0);
    check("rst_win_fail", 32'({bus.win, bus.fail}), 32'd0);
    reset_n = 1'b1;
    chk_en  = 1'b1;

    // Asynchronous reset in the middle of the first lit colour.
    q.delete();
    bus.start   = 1'b1;
    bus.rand_in = 32'h0000_0002;
    cyc(1'b0, RED, 1'b0);
    bus.start = 1'b0;
    m_lvl = 1;
    cyc(1'b1, BLUE, 1'b0);
    cyc(1'b1, BLUE, 1'b0);
    check("show_led_on", 32'(bus.led_on), 32'd1);
    check("show_color", 32'(bus.led_color), 32'd2);
    #1;
    reset_n = 1'b0;
    #1;
    check("arst_led_on", 32'(bus.led_on), 32'd0);
    check("arst_color", 32'(bus.led_color), 32'd0);
    check("arst_level", 32'(bus.level), 32'd0);
    check("arst_await", 32'(bus.awaiting_input), 32'd0);
    m_lvl = 0;
    e_led = 1'b0; e_aw = 1'b0; e_lvl = 0;
    #4;
    reset_n = 1'b1;

    // Round 1: blue.
    start_game(32'h0000_0002, 1'b0);
    check("r1_level", 32'(bus.level), 32'd1);
    check("r1_await", 32'(bus.awaiting_input), 32'd1);

    // start is ignored while waiting for input.
    bus.start = 1'b1;
    cyc(1'b0, RED, 1'b1);
    bus.start = 1'b0;

    // start together with a press in WAIT_IN: only the press counts.
    bus.start = 1'b1;
    press(BLUE);
    bus.start = 1'b0;
    next_round(32'hFFFF_FFF1, 1'b0);
    check("r2_level", 32'(bus.level), 32'd2);

    // Right then wrong press.
    press(BLUE);
    press(YELLOW);
    check("lose_fail", 32'(bus.fail), 32'd1);
    check("lose_level", 32'(bus.level), 32'd2);
    cyc(1'b0, RED, 1'b0);

    // Full game to a win, with ignored presses during one replay.
    start_game(32'h0000_0000, 1'b0);
    check("restart_level", 32'(bus.level), 32'd1);
    press(RED);
    next_round(32'h0000_0003, 1'b0);
    press(RED);
    press(YELLOW);
    next_round(32'h0000_0001, 1'b1);
    press(RED);
    press(YELLOW);
    press(GREEN);
    check("win_win", 32'(bus.win), 32'd1);
    check("win_level", 32'(bus.level), 32'd3);
    check("win_await", 32'(bus.awaiting_input), 32'd0);
    bus.btn_valid = 1'b1;
    bus.btn_color = BLUE;
    cyc(1'b0, RED, 1'b0);
    bus.btn_valid = 1'b0;
    cyc(1'b0, RED, 1'b0);

    // Idle waiting for input.
    start_game(32'h0000_0002, 1'b0);
`ifdef SEQ_TIMEOUT_EN
    repeat (TO_C - 1) cyc(1'b0, RED, 1'b1);
    m_fail = 1'b1;
    cyc(1'b0, RED, 1'b0);
    check("timeout_fail", 32'(bus.fail), 32'd1);
`else
    repeat (100) cyc(1'b0, RED, 1'b1);
    check("no_timeout_await", 32'(bus.awaiting_input), 32'd1);
`endif

    tick();
    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
